// File: rtl/bit_serial_min_n.sv
// ---------------------------------------------------------------------------
// bit_serial_min_n
//
// Purpose:
//   Bit-serial minimum of NUM_CH unsigned words that arrive MSB first. Each
//   beat carries one bit per channel. The minimum also leaves MSB first, one
//   cycle after each accepted beat. No word-wide storage is needed: a
//   candidate mask tracks which channels can still be the minimum.
//
// Optional feature:
//   BSMIN_INDEX_EN - when defined, adds the min_idx port. It reports the
//                    lowest-numbered winning channel, updates with the final
//                    beat and holds until the next end of frame.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a beat is present on in_bits this cycle
//   in_sof     this beat is the MSB of a new frame (qualified by in_valid)
//   in_bits    bit k is the current bit of channel k
//   out_valid  out_bit carries a result bit this cycle
//   out_bit    current bit of the minimum word
//   out_eof    out_bit is the LSB of the frame
//   busy       a frame is in progress
//   proto_err  one-cycle pulse on a protocol violation
//   min_idx    winner channel index (BSMIN_INDEX_EN only)
// ---------------------------------------------------------------------------
module bit_serial_min_n #(
    parameter int  NUM_CH = 3,
    parameter int  DATA_W = 8,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [NUM_CH-1:0] in_bits,
    output logic              out_valid,
    output logic              out_bit,
    output logic              out_eof,
    output logic              busy,
    output logic              proto_err
`ifdef BSMIN_INDEX_EN
    ,
    output logic [IDX_W-1:0]  min_idx
`endif
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [NUM_CH-1:0]  cand;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_CH-1:0]  eff;
    logic [NUM_CH-1:0]  zero_set;
    logic [NUM_CH-1:0]  next_cand;
    logic               beat_bit;
    logic               start;
    logic               cont;
    logic               accept;
    logic               last;
    logic               perr;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        eff       = in_sof ? '1 : cand;
        zero_set  = eff & ~in_bits;
        // If any candidate shows a 0, the minimum has a 0 here and every
        // candidate showing 1 is now known to be larger. If all show 1, the
        // minimum has a 1 and nobody is eliminated.
        beat_bit  = (zero_set == '0);
        next_cand = beat_bit ? eff : zero_set;

        // An SOF beat always starts a frame; in RUN it also abandons the
        // current one. A non-SOF beat only counts while a frame is open.
        start     = in_valid & in_sof;
        cont      = in_valid & ~in_sof & (state == RUN);
        accept    = start | cont;
        last      = cont & (cnt == CNT_W'(DATA_W - 1));
        perr      = in_valid & ((in_sof & (state == RUN)) | (~in_sof & (state == IDLE)));
    end

    assign busy = (state == RUN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_eof   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            out_valid <= accept;
            out_bit   <= accept & beat_bit;
            out_eof   <= last;
            proto_err <= perr;

            if (accept) begin
                cand <= next_cand;
            end

            if (start) begin
                state <= RUN;
                cnt   <= CNT_W'(1);
            end else if (cont) begin
                if (last) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef BSMIN_INDEX_EN
    logic [IDX_W-1:0] win_idx;

    // Scan from the top down so the lowest set index is written last and wins.
    always_comb begin
        win_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (next_cand[k]) begin
                win_idx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_idx <= '0;
        end else if (last) begin
            min_idx <= win_idx;
        end
    end
`endif

endmodule

// File: tb/tb_bit_serial_min_n.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_min_n
//
// Scoreboard bench for bit_serial_min_n (NUM_CH=3, DATA_W=8). The driver
// streams frames and pushes the expected output bits, computed from the
// arithmetic minimum of the words, into a queue. A monitor on the falling
// edge pops one entry for every out_valid cycle and compares. Protocol
// error pulses are counted on both sides and compared at the end.
// ---------------------------------------------------------------------------
module tb_bit_serial_min_n;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int IDX_W  = $clog2(NUM_CH);

    typedef struct {
        logic             bit_v;
        logic             eof;
        logic [IDX_W-1:0] idx;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_sof;
    logic [NUM_CH-1:0] in_bits;
    logic              out_valid;
    logic              out_bit;
    logic              out_eof;
    logic              busy;
    logic              proto_err;
`ifdef BSMIN_INDEX_EN
    logic [IDX_W-1:0]  min_idx;
`endif

    bit_serial_min_n #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_eof   (out_eof),
        .busy      (busy),
        .proto_err (proto_err)
`ifdef BSMIN_INDEX_EN
        ,
        .min_idx   (min_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec;
    int   n_bad;
    int   exp_perr;
    int   obs_perr;
    bit   model_run;
    exp_t exp_q[$];
    logic [DATA_W-1:0] words [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the minimum of the words and the lowest channel holding it.
    task automatic ref_min(output logic [DATA_W-1:0] m, output logic [IDX_W-1:0] idx);
        m   = words[0];
        idx = '0;
        for (int k = 1; k < NUM_CH; k++) begin
            if (words[k] < m) begin
                m   = words[k];
                idx = IDX_W'(k);
            end
        end
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_bits  = '0;
        @(posedge clk);
        #1;
    endtask

    // Streams the first n_beats beats of the frame in 'words'. A set bit b
    // in gap_mask inserts a stall after beat b (1-based).
    task automatic send_frame(input int n_beats, input logic [DATA_W:0] gap_mask);
        logic [DATA_W-1:0] m;
        logic [IDX_W-1:0]  idx;
        exp_t              e;
        ref_min(m, idx);
        if (model_run) exp_perr++;   // SOF inside an open frame
        for (int b = 0; b < n_beats; b++) begin
            in_valid = 1'b1;
            in_sof   = (b == 0);
            for (int k = 0; k < NUM_CH; k++) in_bits[k] = words[k][DATA_W-1-b];
            e.bit_v = m[DATA_W-1-b];
            e.eof   = (b == DATA_W - 1);
            e.idx   = idx;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (gap_mask[b+1]) idle_cycle();
        end
        model_run = (n_beats < DATA_W);
        in_valid  = 1'b0;
        in_sof    = 1'b0;
    endtask

    task automatic set_words(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input logic [DATA_W-1:0] c);
        words[0] = a;
        words[1] = b;
        words[2] = c;
    endtask

    // Monitor: one scoreboard entry per out_valid cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (proto_err) obs_perr++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_bit", 32'(out_bit), 32'(e.bit_v));
                    check("out_eof", 32'(out_eof), 32'(e.eof));
`ifdef BSMIN_INDEX_EN
                    if (e.eof) check("min_idx", 32'(min_idx), 32'(e.idx));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_bad = 0; exp_perr = 0; obs_perr = 0; model_run = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_bits = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bit",   32'(out_bit),   32'd0);
        check("rst_out_eof",   32'(out_eof),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Distinct minimum, tie, all-ones: back to back with no bubble.
        set_words(8'd22, 8'd22, 8'd9);   send_frame(DATA_W, '0);
        set_words(8'd22, 8'd22, 8'd30);  send_frame(DATA_W, '0);
        set_words(8'hFF, 8'hFF, 8'hFF);  send_frame(DATA_W, '0);

        // Stalls after beats 2 and 5; busy must hold through a stall.
        set_words(8'd200, 8'd7, 8'd7);
        send_frame(2, 9'b0_0000_0100);
        check("busy_in_stall", 32'(busy), 32'd1);
        // Finish the frame: replay the full frame expectations minus the 2 sent.
        begin
            logic [DATA_W-1:0] m;
            logic [IDX_W-1:0]  idx;
            exp_t              e;
            ref_min(m, idx);
            for (int b = 2; b < DATA_W; b++) begin
                in_valid = 1'b1;
                in_sof   = 1'b0;
                for (int k = 0; k < NUM_CH; k++) in_bits[k] = words[k][DATA_W-1-b];
                e.bit_v = m[DATA_W-1-b];
                e.eof   = (b == DATA_W - 1);
                e.idx   = idx;
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                if (b == 4) idle_cycle();
            end
            model_run = 1'b0;
            in_valid  = 1'b0;
        end
        idle_cycle();
        check("busy_after_eof", 32'(busy), 32'd0);

        // Premature SOF at beat 4 abandons the frame.
        set_words(8'd100, 8'd50, 8'd77); send_frame(3, '0);
        set_words(8'd13, 8'd200, 8'd12); send_frame(DATA_W, '0);
        idle_cycle();

        // Non-SOF beat while idle is dropped.
        in_valid = 1'b1; in_sof = 1'b0; in_bits = 3'b101;
        exp_perr++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("drop_proto_err", 32'(proto_err), 32'd1);
        check("drop_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        set_words(8'd64, 8'd65, 8'd63);  send_frame(DATA_W, '0);

        // Reset in the middle of a frame.
        set_words(8'd90, 8'd91, 8'd92);  send_frame(4, '0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_bit",   32'(out_bit),   32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        model_run = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_words(8'd5, 8'd3, 8'd9);     send_frame(DATA_W, '0);

        // Random frames: random words, ties, stalls and occasional aborts.
        for (int f = 0; f < 60; f++) begin
            for (int k = 0; k < NUM_CH; k++) words[k] = DATA_W'($urandom);
            if ($urandom_range(0, 3) == 0) words[$urandom_range(0, NUM_CH-1)] = words[0];
            if ($urandom_range(0, 7) == 0) send_frame($urandom_range(1, DATA_W-1), DATA_W'($urandom) & 9'h0AA);
            else                           send_frame(DATA_W, ($urandom_range(0, 1) == 1) ? 9'(DATA_W'($urandom)) & 9'h124 : '0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        // Drain, bounded.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle_cycle();
        idle_cycle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("proto_err_count", 32'(obs_perr), 32'(exp_perr));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
